free_list: RTL and testbench
============================

Name: free_list

Overview:
- Circular queue of free physical register (PR) indices for the R10K-style rename stage.
- Feeds dispatch with the new PR tag T, which goes to the ROB, the map table and the RS.
- Consumes the ROB retire output: the retiring head's T_old is pushed back into the queue.
- On branch rollback, restores its head pointer from a per-ROB-entry snapshot, so PRs allocated by squashed instructions become free again.

Parameters:
NUM_PR, 64, number of physical registers
NUM_ARCH, 32, number of architectural registers; PRs 0..NUM_ARCH-1 are mapped at reset
NUM_ROB, 32, ROB entries; sets snapshot table depth
FL_DEPTH, NUM_PR-NUM_ARCH, queue capacity (power of two)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  global enable; all state holds when 0
dispatch_en  in  1  instruction dispatching this cycle
dest_valid  in  1  dispatching instruction writes a register (dest != zero reg)
rob_tail_idx  in  clog2(NUM_ROB)  ROB index being written by this dispatch
retire_en  in  1  ROB head retiring this cycle
retire_dest_valid  in  1  retiring instruction owns a T_old to free
T_old_idx_head  in  clog2(NUM_PR)  T_old of the retiring ROB head
rollback_en  in  1  branch mispredict rollback
ROB_rollback_idx  in  clog2(NUM_ROB)  ROB index of the mispredicted branch (survives)
free_valid  out  1  at least one free PR available
T_idx  out  clog2(NUM_PR)  PR handed to the current dispatch
free_count  out  clog2(FL_DEPTH)+1  number of free PRs

Behaviour:
- Reset state:
  - buf[i] = NUM_ARCH+i for i = 0..FL_DEPTH-1.
  - head = 0, tail = 0, count = FL_DEPTH.
  - All snapshots = 0.
  - Outputs: free_valid = 1, T_idx = NUM_ARCH, free_count = FL_DEPTH.
  - Reset has priority over en and over every other input; it aborts any in-flight rollback.
- Outputs are combinational from registered state only (no bypass):
  - free_valid = (count != 0); T_idx = buf[head]; free_count = count.
- Pop:
  - Condition: pop = en & dispatch_en & dest_valid & free_valid & !rollback_en.
  - Action: head <= head+1 mod FL_DEPTH. T_idx is consumed in the same cycle it is presented.
- Snapshot:
  - Condition: en & dispatch_en & !rollback_en, with or without a pop.
  - Action: snap[rob_tail_idx] <= head after this cycle's pop (head+pop).
- Push:
  - Condition: push = en & retire_en & retire_dest_valid.
  - Action: buf[tail] <= T_old_idx_head; tail <= tail+1 mod FL_DEPTH.
- Rollback (en & rollback_en):
  - head <= snap[ROB_rollback_idx].
  - reclaimed = (head - snap[ROB_rollback_idx]) mod FL_DEPTH.
  - count <= count + reclaimed + push.
  - Dispatch is ignored that cycle; a push in the same cycle still happens.
  - Reclaimed slots lie between the restored head and the current head. Pushes land only at tail, so those slots are never overwritten and their contents are intact.
- Count, normal cycle: count <= count + push - pop. Pop and push in the same cycle leave count unchanged.
- Empty (count == 0):
  - free_valid = 0 and no pop occurs. Upstream must stall dispatch.
  - A same-cycle push does not bypass to T_idx; the pushed PR is visible next cycle.
- Full (count == FL_DEPTH): a push without a pop is illegal. Assertion in simulation; in RTL count saturates and the push is dropped.
- Wrap-around: head, tail and reclaimed arithmetic are mod FL_DEPTH. count is one bit wider so full and empty are distinguishable.
- dispatch_en & dest_valid & !free_valid: the request is ignored; T_idx is don't-care.
- en = 0: no state change; outputs still reflect registered state.

Test Plan:
- Reset → free_valid=1, T_idx=32, free_count=32. Four consecutive pops → T_idx 32,33,34,35 in successive cycles; free_count=28.
- Drain all 32 with no retire → free_valid=0, free_count=0. Next dispatch is ignored. Retire with T_old=5 → next cycle free_valid=1, T_idx=5.
- Same-cycle pop and push (T_old=7) at count=10 → count stays 10; 7 is written at tail; T_idx advances by one.
- Dispatch ROB idx 3 with PR 32 (branch), then idx 4,5 with PRs 33,34. Rollback_en with ROB_rollback_idx=3 → head points to PR 33, free_count +2. Next two pops return 33,34.
- Rollback to idx 30 after dispatches wrap ROB idx 30→1 and FL head wraps 31→0 → head restored correctly across the wrap; reclaimed count correct mod 32.
- Reset asserted mid-rollback together with en=0 → reset state restored exactly as after the initial reset.

Source files
------------

// File: rtl/free_list.sv
// Free physical-register queue for the rename stage: hands out new PR tags at
// dispatch, takes back T_old at retire and rewinds its head on branch rollback.
module free_list #(
    parameter int NUM_PR   = 64,
    parameter int NUM_ARCH = 32,
    parameter int NUM_ROB  = 32,
    parameter int FL_DEPTH = NUM_PR - NUM_ARCH,
    localparam int PRW     = $clog2(NUM_PR),
    localparam int ROBW    = $clog2(NUM_ROB),
    localparam int PTRW    = $clog2(FL_DEPTH),
    localparam int CNTW    = PTRW + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic            dispatch_en,
    input  logic            dest_valid,
    input  logic [ROBW-1:0] rob_tail_idx,
    input  logic            retire_en,
    input  logic            retire_dest_valid,
    input  logic [PRW-1:0]  T_old_idx_head,
    input  logic            rollback_en,
    input  logic [ROBW-1:0] ROB_rollback_idx,
    output logic            free_valid,
    output logic [PRW-1:0]  T_idx,
    output logic [CNTW-1:0] free_count
);

    localparam logic [CNTW:0] FULL_EXT = (CNTW+1)'(FL_DEPTH);

    logic [PRW-1:0]  r_buf  [FL_DEPTH];
    logic [PTRW-1:0] r_snap [NUM_ROB];
    logic [PTRW-1:0] r_head;
    logic [PTRW-1:0] r_tail;
    logic [CNTW-1:0] r_count;

    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_rb;
    logic            w_snap_we;
    logic [PTRW-1:0] w_head_pop;
    logic [PTRW-1:0] w_rb_head;
    logic [PTRW-1:0] w_reclaimed;
    logic [CNTW:0]   w_base;
    logic [CNTW:0]   w_count_ext;
    logic [CNTW-1:0] w_count_next;

    assign w_pop       = en & dispatch_en & dest_valid & free_valid & ~rollback_en;
    assign w_push_req  = en & retire_en & retire_dest_valid;
    assign w_rb        = en & rollback_en;
    assign w_snap_we   = en & dispatch_en & ~rollback_en;
    assign w_head_pop  = r_head + PTRW'(w_pop);
    assign w_rb_head   = r_snap[ROB_rollback_idx];
    // Pointers are FL_DEPTH-wide power-of-two counters, so wrap is implicit.
    assign w_reclaimed = r_head - w_rb_head;

    // Occupancy before the push is considered; a push only lands if there is room.
    always_comb begin
        w_base       = {(CNTW+1){1'b0}};
        w_push       = 1'b0;
        w_count_ext  = {(CNTW+1){1'b0}};
        w_count_next = r_count;
        if (w_rb) begin
            w_base = {1'b0, r_count} + (CNTW+1)'(w_reclaimed);
        end else begin
            w_base = {1'b0, r_count} - (CNTW+1)'(w_pop);
        end
        w_push      = w_push_req & (w_base < FULL_EXT);
        w_count_ext = w_base + (CNTW+1)'(w_push);
        if (w_count_ext > FULL_EXT) begin
            w_count_next = CNTW'(FL_DEPTH);
        end else begin
            w_count_next = w_count_ext[CNTW-1:0];
        end
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_buf[i] <= PRW'(NUM_ARCH + i);
            end
            r_head  <= {PTRW{1'b0}};
            r_tail  <= {PTRW{1'b0}};
            r_count <= CNTW'(FL_DEPTH);
        end else begin
            if (w_push) begin
                r_buf[r_tail] <= T_old_idx_head;
                r_tail        <= r_tail + {{(PTRW-1){1'b0}}, 1'b1};
            end else begin
                r_tail <= r_tail;
            end
            if (w_rb) begin
                r_head <= w_rb_head;
            end else begin
                r_head <= w_head_pop;
            end
            if (en) begin
                r_count <= w_count_next;
            end else begin
                r_count <= r_count;
            end
        end
    end

    // Per-ROB-entry head snapshot, taken after this cycle's pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < NUM_ROB; j++) begin
                r_snap[j] <= {PTRW{1'b0}};
            end
        end else if (w_snap_we) begin
            r_snap[rob_tail_idx] <= w_head_pop;
        end else begin
            r_snap[rob_tail_idx] <= r_snap[rob_tail_idx];
        end
    end

    assign free_valid = (r_count != {CNTW{1'b0}});
    assign T_idx      = r_buf[r_head];
    assign free_count = r_count;

    free_list_chk #(
        .CNTW     (CNTW),
        .FL_DEPTH (FL_DEPTH)
    ) u_chk (
        .clock    (clock),
        .reset    (reset),
        .push_req (w_push_req),
        .pop      (w_pop),
        .rollback (w_rb),
        .count    (r_count)
    );

endmodule

// Flags a retire push into a full queue with no pop to make room.
module free_list_chk #(
    parameter int CNTW     = 6,
    parameter int FL_DEPTH = 32
) (
    input logic            clock,
    input logic            reset,
    input logic            push_req,
    input logic            pop,
    input logic            rollback,
    input logic [CNTW-1:0] count
);

    // Push-without-pop while full is an upstream protocol error.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(push_req && !pop && !rollback && (count == CNTW'(FL_DEPTH))))
                else $error("free_list: push while full");
        end else begin
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset, pop/push, empty, rollback and wrap cases.
module tb_free_list;

    logic       clock;
    logic       reset;
    logic       en;
    logic       dispatch_en;
    logic       dest_valid;
    logic [4:0] rob_tail_idx;
    logic       retire_en;
    logic       retire_dest_valid;
    logic [5:0] T_old_idx_head;
    logic       rollback_en;
    logic [4:0] ROB_rollback_idx;
    logic       free_valid;
    logic [5:0] T_idx;
    logic [5:0] free_count;

    int checks = 0;
    int errors = 0;

    free_list dut (
        .clock             (clock),
        .reset             (reset),
        .en                (en),
        .dispatch_en       (dispatch_en),
        .dest_valid        (dest_valid),
        .rob_tail_idx      (rob_tail_idx),
        .retire_en         (retire_en),
        .retire_dest_valid (retire_dest_valid),
        .T_old_idx_head    (T_old_idx_head),
        .rollback_en       (rollback_en),
        .ROB_rollback_idx  (ROB_rollback_idx),
        .free_valid        (free_valid),
        .T_idx             (T_idx),
        .free_count        (free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctl();
        dispatch_en       = 1'b0;
        dest_valid        = 1'b0;
        retire_en         = 1'b0;
        retire_dest_valid = 1'b0;
        rollback_en       = 1'b0;
    endtask

    task automatic do_pop(input int rob);
        dispatch_en  = 1'b1;
        dest_valid   = 1'b1;
        rob_tail_idx = 5'(rob);
        tick();
        clear_ctl();
    endtask

    task automatic do_push(input int t);
        retire_en         = 1'b1;
        retire_dest_valid = 1'b1;
        T_old_idx_head    = 6'(t);
        tick();
        clear_ctl();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        en               = 1'b1;
        rob_tail_idx     = 5'd0;
        T_old_idx_head   = 6'd0;
        ROB_rollback_idx = 5'd0;
        clear_ctl();
        do_reset();

        chk("rst_valid", 32'(free_valid), 32'd1);
        chk("rst_tidx", 32'(T_idx), 32'd32);
        chk("rst_count", 32'(free_count), 32'd32);

        for (int k = 0; k < 4; k++) begin
            chk("pop4_tidx", 32'(T_idx), 32'(32 + k));
            do_pop(k);
        end
        chk("pop4_count", 32'(free_count), 32'd28);

        for (int k = 0; k < 28; k++) do_pop(4 + k);
        chk("drain_valid", 32'(free_valid), 32'd0);
        chk("drain_count", 32'(free_count), 32'd0);

        dispatch_en  = 1'b1;
        dest_valid   = 1'b1;
        rob_tail_idx = 5'd0;
        tick();
        clear_ctl();
        chk("empty_ign_count", 32'(free_count), 32'd0);
        chk("empty_ign_valid", 32'(free_valid), 32'd0);

        retire_en         = 1'b1;
        retire_dest_valid = 1'b1;
        T_old_idx_head    = 6'd5;
        chk("no_bypass", 32'(free_valid), 32'd0);
        tick();
        clear_ctl();
        chk("refill_valid", 32'(free_valid), 32'd1);
        chk("refill_tidx", 32'(T_idx), 32'd5);
        chk("refill_count", 32'(free_count), 32'd1);

        for (int k = 0; k < 9; k++) do_push(40 + k);
        chk("count10", 32'(free_count), 32'd10);

        dispatch_en       = 1'b1;
        dest_valid        = 1'b1;
        rob_tail_idx      = 5'd7;
        retire_en         = 1'b1;
        retire_dest_valid = 1'b1;
        T_old_idx_head    = 6'd7;
        tick();
        clear_ctl();
        chk("poppush_count", 32'(free_count), 32'd10);
        chk("poppush_tidx", 32'(T_idx), 32'd40);
        for (int k = 0; k < 9; k++) begin
            chk("poppush_seq", 32'(T_idx), 32'(40 + k));
            do_pop(8 + k);
        end
        chk("tail_write", 32'(T_idx), 32'd7);
        chk("tail_count", 32'(free_count), 32'd1);

        do_reset();
        do_pop(3);
        do_pop(4);
        do_pop(5);
        chk("rb_pre_count", 32'(free_count), 32'd29);
        rollback_en      = 1'b1;
        ROB_rollback_idx = 5'd3;
        dispatch_en      = 1'b1;
        dest_valid       = 1'b1;
        rob_tail_idx     = 5'd9;
        tick();
        clear_ctl();
        chk("rb_count", 32'(free_count), 32'd31);
        chk("rb_tidx0", 32'(T_idx), 32'd33);
        do_pop(4);
        chk("rb_tidx1", 32'(T_idx), 32'd34);
        do_pop(5);
        chk("rb_post_count", 32'(free_count), 32'd29);

        do_reset();
        for (int k = 0; k < 30; k++) do_pop(k);
        chk("wrap_pre_count", 32'(free_count), 32'd2);
        chk("wrap_pre_tidx", 32'(T_idx), 32'd62);
        for (int k = 1; k <= 4; k++) do_push(k);
        chk("wrap_push_count", 32'(free_count), 32'd6);
        do_pop(30);
        do_pop(31);
        do_pop(0);
        do_pop(1);
        chk("wrap_disp_count", 32'(free_count), 32'd2);
        chk("wrap_disp_tidx", 32'(T_idx), 32'd3);
        rollback_en       = 1'b1;
        ROB_rollback_idx  = 5'd30;
        retire_en         = 1'b1;
        retire_dest_valid = 1'b1;
        T_old_idx_head    = 6'd9;
        tick();
        clear_ctl();
        chk("wrap_rb_count", 32'(free_count), 32'd6);
        chk("wrap_rb_tidx", 32'(T_idx), 32'd63);
        do_pop(2);
        chk("wrap_pop_tidx", 32'(T_idx), 32'd1);
        chk("wrap_pop_count", 32'(free_count), 32'd5);

        en                = 1'b0;
        dispatch_en       = 1'b1;
        dest_valid        = 1'b1;
        retire_en         = 1'b1;
        retire_dest_valid = 1'b1;
        T_old_idx_head    = 6'd11;
        tick();
        clear_ctl();
        chk("hold_count", 32'(free_count), 32'd5);
        chk("hold_tidx", 32'(T_idx), 32'd1);

        reset            = 1'b1;
        rollback_en      = 1'b1;
        ROB_rollback_idx = 5'd30;
        dispatch_en      = 1'b1;
        dest_valid       = 1'b1;
        tick();
        reset = 1'b0;
        en    = 1'b1;
        clear_ctl();
        chk("rst2_valid", 32'(free_valid), 32'd1);
        chk("rst2_tidx", 32'(T_idx), 32'd32);
        chk("rst2_count", 32'(free_count), 32'd32);

        rollback_en      = 1'b1;
        ROB_rollback_idx = 5'd30;
        tick();
        clear_ctl();
        chk("rst2_snap_tidx", 32'(T_idx), 32'd32);
        chk("rst2_snap_count", 32'(free_count), 32'd32);
        do_pop(0);
        chk("rst2_pop_tidx", 32'(T_idx), 32'd33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
